pc_sequencer: RTL and testbench

//  Program-counter stage fed by the control unit. Consumes flagPC/flagJR and jump targets, and

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_sequencer_delay_counter.sv | 35 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter definitions: PC command codes issued by the control
// unit and the encoding of the sequencer's delay FSM.
package pc_pkg;

  // PC command carried on flagPC; the control unit uses the same codes.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_JUMP  = 2'd2,
    PC_DELAY = 2'd3
  } pc_cmd_e;

  // Sequencer FSM: RUN decodes commands, DELAY stretches a delay instruction.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_delay_counter.sv
// Delay down-counter for pc_sequencer: loads a length, decrements once per
// enabled clock and flags the decrement that brings it to zero.
module delay_counter
  import pc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Count register: load has priority, decrement saturates at zero.
  // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // The current decrement is the last one when it lands on zero; a count that
  // is already zero also ends the delay so the FSM can never get stuck.
  assign o_last = (r_count <= CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds, increments or jumps the instruction address
// on flagPC commands and stretches delay instructions over many clocks.
// Build option: define DELAY_CFG_EN to take the delay length from the
// delay_value port (sampled when the delay starts); otherwise every delay
// lasts DELAY_CYCLES clocks and the port does not exist.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 32,
  parameter int unsigned DELAY_CYCLES = 50_000_000,
  parameter int          CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        flagPC,
  input  logic              flagJR,
  input  logic [ADDR_W-1:0] imm_target,
  input  logic [DATA_W-1:0] reg_target,
`ifdef DELAY_CFG_EN
  input  logic [CNT_W-1:0]  delay_value,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              delay_busy,
  output logic              delay_done
);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_busy;
  logic              r_done;

  seq_state_e        w_state_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_done_next;
  logic              w_load;
  logic              w_dec;
  logic              w_last;
  logic [CNT_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_load_value;

  // Delay length: taken straight from the operand when configurable, else fixed.
`ifdef DELAY_CFG_EN
  assign w_len = delay_value;
`else
  assign w_len = CNT_W'(DELAY_CYCLES);
`endif

  // The RUN decode cycle already counts as the first cycle of the delay.
  assign w_load_value = w_len - CNT_W'(1);
  assign w_pc_inc     = r_pc + ADDR_W'(1);

  // Only the low ADDR_W bits of the register operand form a jump target.
  if (DATA_W > ADDR_W) begin : g_reg_hi
    logic w_unused_reg_hi;
    assign w_unused_reg_hi = ^reg_target[DATA_W-1:ADDR_W];
  end

  delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_counter (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_dec        (w_dec),
    .o_last       (w_last)
  );

  // Next-state, next-pc and counter control for the RUN/DELAY FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        unique case (pc_cmd_e'(flagPC))
          PC_HOLD: ;
          PC_INC:  w_pc_next = w_pc_inc;
          PC_JUMP: w_pc_next = flagJR ? reg_target[ADDR_W-1:0] : imm_target;
          PC_DELAY: begin
            if (w_len <= CNT_W'(1)) begin
              // Zero/one-cycle delay behaves like an ordinary instruction.
              w_pc_next   = w_pc_inc;
              w_done_next = 1'b1;
            end else begin
              w_load       = 1'b1;
              w_state_next = ST_DELAY;
            end
          end
        endcase
      end
      ST_DELAY: begin
        // flagPC is ignored here: only reset can cancel a running delay.
        w_dec = 1'b1;
        if (w_last) begin
          w_pc_next    = w_pc_inc;
          w_state_next = ST_RUN;
          w_done_next  = 1'b1;
        end
      end
    endcase
  end

  // State, pc and registered status outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_busy  <= (w_state_next == ST_DELAY);
      r_done  <= w_done_next;
    end
  end

  assign pc         = r_pc;
  assign delay_busy = r_busy;
  assign delay_done = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=10, DATA_W=32, DELAY_CYCLES=4).
// Each step drives one clock's worth of inputs, pushes the expected post-edge
// outputs to a scoreboard, then pops and compares after the edge.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic [1:0]  flagPC;
  logic        flagJR;
  logic [9:0]  imm_target;
  logic [31:0] reg_target;
  logic [31:0] delay_value;
  logic [9:0]  pc;
  logic        delay_busy;
  logic        delay_done;

  typedef struct {
    logic        rst;
    logic [1:0]  f;
    logic        jr;
    logic [9:0]  imm;
    logic [31:0] rt;
    logic [31:0] dv;
    logic [9:0]  pc;
    logic        busy;
    logic        done;
  } step_t;

  typedef struct {
    logic [9:0] pc;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(
    .ADDR_W       (10),
    .DATA_W       (32),
    .DELAY_CYCLES (4),
    .CNT_W        (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flagPC      (flagPC),
    .flagJR      (flagJR),
    .imm_target  (imm_target),
    .reg_target  (reg_target),
`ifdef DELAY_CFG_EN
    .delay_value (delay_value),
`endif
    .pc          (pc),
    .delay_busy  (delay_busy),
    .delay_done  (delay_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic step_t mk(input logic rst, input logic [1:0] f, input logic jr,
                               input logic [9:0] imm, input logic [31:0] rt, input logic [31:0] dv,
                               input logic [9:0] epc, input logic ebusy, input logic edone);
    step_t s;
    s.rst = rst; s.f = f; s.jr = jr; s.imm = imm; s.rt = rt; s.dv = dv;
    s.pc = epc; s.busy = ebusy; s.done = edone;
    return s;
  endfunction

  // Drive one step at the falling edge, record its expectation, sample after the rising edge.
  task automatic drive(input step_t s, input string tag);
    @(negedge clock);
    reset       = s.rst;
    flagPC      = s.f;
    flagJR      = s.jr;
    imm_target  = s.imm;
    reg_target  = s.rt;
    delay_value = s.dv;
    sb.push_back('{pc: s.pc, busy: s.busy, done: s.done, tag: tag});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t st[5];
    exp_t  e;
    st = '{mk(0, 1, 0, 10'h0, 0, 0, 10'h000, 0, 0),
           mk(0, 1, 0, 10'h0, 0, 0, 10'h000, 0, 0),
           mk(1, 1, 0, 10'h0, 0, 0, 10'h001, 0, 0),
           mk(1, 1, 0, 10'h0, 0, 0, 10'h002, 0, 0),
           mk(1, 1, 0, 10'h0, 0, 0, 10'h003, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "reset_inc");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  task automatic test_wrap_jump();
    step_t st[5];
    exp_t  e;
    st = '{mk(1, 2, 0, 10'h3FF, 32'h0,         0, 10'h3FF, 0, 0),
           mk(1, 1, 0, 10'h000, 32'h0,         0, 10'h000, 0, 0),
           mk(1, 2, 0, 10'h155, 32'hFFFF_F3A7, 0, 10'h155, 0, 0),
           mk(1, 2, 1, 10'h155, 32'hFFFF_F3A7, 0, 10'h3A7, 0, 0),
           mk(1, 2, 0, 10'h2AA, 32'hFFFF_F3A7, 0, 10'h2AA, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "wrap_jump");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  // Fixed length 4: pc=7 for 4 cycles including the decode cycle, busy for 3.
  task automatic test_delay_fixed();
    step_t st[6];
    exp_t  e;
    st = '{mk(1, 2, 0, 10'h007, 0, 0, 10'h007, 0, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h007, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h007, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h007, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h008, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h008, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "delay_fixed");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  // flagPC dropped to 0 mid-delay: the delay still finishes on schedule.
  task automatic test_delay_interrupt();
    step_t st[5];
    exp_t  e;
    st = '{mk(1, 3, 0, 10'h000, 0, 0, 10'h008, 1, 0),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h008, 1, 0),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h008, 1, 0),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h009, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h009, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "delay_interrupt");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  // Reset aborts a delay without a done pulse; a fresh delay then runs in full.
  task automatic test_reset_mid_delay();
    step_t st[9];
    exp_t  e;
    st = '{mk(1, 3, 0, 10'h000, 0, 0, 10'h009, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h009, 1, 0),
           mk(0, 3, 0, 10'h000, 0, 0, 10'h000, 0, 0),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h000, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h000, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h000, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h001, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h001, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "reset_mid_delay");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  // flagPC=0 for 10 cycles with changing jump operands: pc must not move.
  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(mk(1, 0, i[0], 10'(i * 37 + 5), $urandom, 0, 10'h001, 0, 0), "hold");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  // Increment and jump alternating every cycle: each edge must take effect.
  task automatic test_back_to_back();
    step_t st[8];
    exp_t  e;
    st = '{mk(1, 1, 0, 10'h000, 32'h0,         0, 10'h002, 0, 0),
           mk(1, 2, 0, 10'h100, 32'h0,         0, 10'h100, 0, 0),
           mk(1, 1, 0, 10'h000, 32'h0,         0, 10'h101, 0, 0),
           mk(1, 2, 1, 10'h011, 32'hABCD_E3FE, 0, 10'h3FE, 0, 0),
           mk(1, 1, 0, 10'h000, 32'h0,         0, 10'h3FF, 0, 0),
           mk(1, 2, 0, 10'h010, 32'h0,         0, 10'h010, 0, 0),
           mk(1, 1, 0, 10'h000, 32'h0,         0, 10'h011, 0, 0),
           mk(1, 2, 1, 10'h3C0, 32'h0000_0007, 0, 10'h007, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "back_to_back");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask

`ifdef DELAY_CFG_EN
  // Length 6 sampled at entry (later change to 2 ignored); lengths 0 and 1 act as one cycle.
  task automatic test_delay_cfg();
    step_t st[13];
    exp_t  e;
    st = '{mk(1, 2, 0, 10'h012, 0, 0, 10'h012, 0, 0),
           mk(1, 3, 0, 10'h000, 0, 6, 10'h012, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 2, 10'h012, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 2, 10'h012, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 2, 10'h012, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 2, 10'h012, 1, 0),
           mk(1, 3, 0, 10'h000, 0, 2, 10'h013, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 2, 10'h013, 0, 0),
           mk(1, 3, 0, 10'h000, 0, 0, 10'h014, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 0, 10'h014, 0, 0),
           mk(1, 3, 0, 10'h000, 0, 1, 10'h015, 0, 1),
           mk(1, 0, 0, 10'h000, 0, 1, 10'h015, 0, 0),
           mk(1, 0, 0, 10'h000, 0, 9, 10'h015, 0, 0)};
    foreach (st[i]) begin
      drive(st[i], "delay_cfg");
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || delay_busy !== e.busy || delay_done !== e.done) begin
        failures++;
        $display("FAIL %s step %0d: pc=%0h busy=%0b done=%0b, expected pc=%0h busy=%0b done=%0b",
                 e.tag, i, pc, delay_busy, delay_done, e.pc, e.busy, e.done);
      end
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    flagPC      = 2'd0;
    flagJR      = 1'b0;
    imm_target  = '0;
    reg_target  = '0;
    delay_value = '0;
    test_reset();
    test_wrap_jump();
    test_delay_fixed();
    test_delay_interrupt();
    test_reset_mid_delay();
    test_hold();
    test_back_to_back();
`ifdef DELAY_CFG_EN
    test_delay_cfg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case the clocking ever stalls.
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
